// File: rtl/array_b_buffer_loader_if.sv
// Stream-in and B-buffer write bundle of the B operand loader.
// The slave modport is the loader; the master modport is its environment.
interface array_b_buffer_loader_if #(
   parameter int ARRAY_WIDTH          = 4,
   parameter int BUFFER_ADDRESS_WIDTH = 10,
   parameter int DATA_WIDTH           = 8
);
   logic [DATA_WIDTH-1:0]             s_data;
   logic                              s_valid;
   logic                              s_ready;
   logic                              b_wr_en;
   logic [BUFFER_ADDRESS_WIDTH-1:0]   b_wr_addr;
   logic [ARRAY_WIDTH*DATA_WIDTH-1:0] b_wr_data;
   logic                              done;

   modport slave (
      input  s_data, s_valid,
      output s_ready, b_wr_en, b_wr_addr, b_wr_data, done
   );

   modport master (
      output s_data, s_valid,
      input  s_ready, b_wr_en, b_wr_addr, b_wr_data, done
   );
endinterface

// File: rtl/array_b_buffer_loader.sv
// Packs a row-major B element stream into ARRAY_WIDTH-lane words and
// writes them column-block major (addr = colblock*n + row).
module array_b_buffer_loader #(
   parameter int ARRAY_WIDTH          = 4,
   parameter int BUFFER_ADDRESS_WIDTH = 10,
   parameter int DATA_WIDTH           = 8
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        start_i,
   input  logic [15:0]                 n,
   input  logic [15:0]                 p,
   array_b_buffer_loader_if.slave      bif
);
   localparam int LG  = $clog2(ARRAY_WIDTH);
   localparam int EW  = (LG > 0) ? LG : 1;
   localparam int ABW = BUFFER_ADDRESS_WIDTH;
   localparam int WW  = ARRAY_WIDTH * DATA_WIDTH;

   typedef enum logic {IDLE, LOAD} state_e;

   state_e         state_q, state_d;
   logic [15:0]    n_q, n_d;
   logic [15:0]    cbl_q, cbl_d;
   logic [15:0]    cb_q, cb_d;
   logic [15:0]    row_q, row_d;
   logic [EW-1:0]  elem_q, elem_d;
   logic [ABW-1:0] ptr_q, ptr_d;
   logic [ABW-1:0] addr_q, addr_d;
   logic [WW-1:0]  pack_q, pack_d;
   logic [WW-1:0]  data_q, data_d;
   logic           rdy_q, rdy_d;
   logic           wr_q, wr_d;
   logic           done_q, done_d;

   logic acc, lane_last, cb_last, row_last;

   assign acc       = bif.s_valid & rdy_q;
   assign lane_last = (elem_q == EW'(ARRAY_WIDTH - 1));
   assign cb_last   = (cb_q == cbl_q - 16'd1);
   assign row_last  = (row_q == n_q - 16'd1);

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      cbl_d   = cbl_q;
      cb_d    = cb_q;
      row_d   = row_q;
      elem_d  = elem_q;
      ptr_d   = ptr_q;
      addr_d  = addr_q;
      data_d  = data_q;
      pack_d  = pack_q;
      wr_d    = 1'b0;
      done_d  = 1'b0;

      for (int i = 0; i < ARRAY_WIDTH; i++) begin
         if (acc && elem_q == EW'(i))
            pack_d[i*DATA_WIDTH +: DATA_WIDTH] = bif.s_data;
      end

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = LOAD;
               n_d     = n;
               cbl_d   = p >> LG;
               cb_d    = '0;
               row_d   = '0;
               elem_d  = '0;
               ptr_d   = '0;
            end
         end
         LOAD: begin
            if (acc) begin
               elem_d = lane_last ? '0 : elem_q + EW'(1);
               if (lane_last) begin
                  // pack_d already holds the final lane of this beat
                  wr_d   = 1'b1;
                  data_d = pack_d;
                  addr_d = ptr_q;
                  if (cb_last) begin
                     cb_d  = '0;
                     row_d = row_q + 16'd1;
                     ptr_d = ABW'(row_q + 16'd1);
                     if (row_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                     end
                  end else begin
                     cb_d  = cb_q + 16'd1;
                     ptr_d = ptr_q + ABW'(n_q);
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      rdy_d = (state_d == LOAD);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         n_q     <= '0;
         cbl_q   <= '0;
         cb_q    <= '0;
         row_q   <= '0;
         elem_q  <= '0;
         ptr_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         pack_q  <= '0;
         rdy_q   <= 1'b0;
         wr_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         cbl_q   <= cbl_d;
         cb_q    <= cb_d;
         row_q   <= row_d;
         elem_q  <= elem_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         pack_q  <= pack_d;
         rdy_q   <= rdy_d;
         wr_q    <= wr_d;
         done_q  <= done_d;
      end
   end

   assign bif.s_ready   = rdy_q;
   assign bif.b_wr_en   = wr_q;
   assign bif.b_wr_addr = addr_q;
   assign bif.b_wr_data = data_q;
   assign bif.done      = done_q;
endmodule
